// File: rtl/record_serializer.sv
// Serializes fixed-width timetag records into the FX2 sample byte stream.
// A shifter plus a one-record hold register allows records to stream with no gap between them.
module record_serializer #(
  parameter int REC_BYTES = 6,
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic                   fx2_clk,
  input  logic                   reset,
  input  logic [8*REC_BYTES-1:0] record,
  input  logic                   record_valid,
  output logic                   record_ready,
  output logic [7:0]             sample,
  output logic                   sample_rdy,
  input  logic                   sample_ack,
  output logic                   busy,
  output logic [CNT_W-1:0]       records_sent
);

  localparam int REC_W = 8 * REC_BYTES;
  localparam int IDX_W = $clog2(REC_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [REC_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [REC_W-1:0]   hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
  logic [7:0]         sample_q, sample_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic accept;
  logic ack;
  logic last_ack;

  assign accept   = record_valid && !hold_valid_q;
  assign ack      = sample_ack && (state_q == SEND);
  assign last_ack = ack && (idx_q == LAST_IDX);

  // Byte index is scaled by 8 by appending three zero bits, so the select width tracks REC_W.
  function automatic logic [7:0] pick_byte(input logic [REC_W-1:0] v,
                                           input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] b;
    b = (LSB_FIRST != 0) ? i : LAST_IDX - i;
    return v[{b, 3'b000} +: 8];
  endfunction

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    cnt_d        = cnt_q;

    if (state_q == IDLE) begin
      if (accept) begin
        shift_d = record;
        idx_d   = '0;
        state_d = SEND;
      end
    end else if (ack) begin
      if (!last_ack) begin
        idx_d = idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (hold_valid_q) begin
          shift_d      = hold_q;
          idx_d        = '0;
          hold_valid_d = 1'b0;
        end else if (accept) begin
          shift_d = record;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
    end

    // A record arriving while the shifter is busy parks in hold unless it was loaded directly above.
    if ((state_q == SEND) && accept && !last_ack) begin
      hold_d       = record;
      hold_valid_d = 1'b1;
    end

    sample_d = (state_d == SEND) ? pick_byte(shift_d, idx_d) : sample_q;
  end

  // NOTE: data registers are reset along with the flags so a mid-record reset leaves nothing stale.
  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      sample_q     <= '0;
      cnt_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      sample_q     <= sample_d;
      cnt_q        <= cnt_d;
    end
  end

  assign record_ready = !hold_valid_q;
  assign sample       = sample_q;
  assign sample_rdy   = (state_q == SEND);
  assign busy         = (state_q == SEND) || hold_valid_q;
  assign records_sent = cnt_q;

endmodule

// File: tb/tb_record_serializer.sv
// Scoreboard bench for record_serializer: a default 6-byte LSB-first instance and
// a 4-byte MSB-first instance with a 4-bit counter to exercise wrap.
module tb_record_serializer;

  logic clk = 1'b0;
  logic reset;

  logic [47:0] rec_a;
  logic        valid_a, ready_a, rdy_a, ack_a, busy_a;
  logic [7:0]  sample_a;
  logic [15:0] sent_a;

  logic [31:0] rec_b;
  logic        valid_b, ready_b, rdy_b, ack_b, busy_b;
  logic [7:0]  sample_b;
  logic [3:0]  sent_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] exp_a, exp_b;

  always #5 clk = ~clk;

  record_serializer u_dut_a (
    .fx2_clk      (clk),
    .reset        (reset),
    .record       (rec_a),
    .record_valid (valid_a),
    .record_ready (ready_a),
    .sample       (sample_a),
    .sample_rdy   (rdy_a),
    .sample_ack   (ack_a),
    .busy         (busy_a),
    .records_sent (sent_a)
  );

  record_serializer #(.REC_BYTES(4), .LSB_FIRST(0), .CNT_W(4)) u_dut_b (
    .fx2_clk      (clk),
    .reset        (reset),
    .record       (rec_b),
    .record_valid (valid_b),
    .record_ready (ready_b),
    .sample       (sample_b),
    .sample_rdy   (rdy_b),
    .sample_ack   (ack_b),
    .busy         (busy_b),
    .records_sent (sent_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every consumed byte is compared against the head of its expected queue.
  always @(negedge clk) begin
    if (!reset && rdy_a && ack_a) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_a: got unexpected byte %02h, expected none", sample_a);
      end else begin
        exp_a = qa.pop_front();
        check("sb_a byte", sample_a, exp_a);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && rdy_b && ack_b) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_b: got unexpected byte %02h, expected none", sample_b);
      end else begin
        exp_b = qb.pop_front();
        check("sb_b byte", sample_b, exp_b);
      end
    end
  end

  task automatic push_a(input logic [47:0] r);
    for (int k = 0; k < 6; k++) qa.push_back(r[8*k +: 8]);
  endtask

  task automatic push_b(input logic [31:0] r);
    for (int k = 3; k >= 0; k--) qb.push_back(r[8*k +: 8]);
  endtask

  task automatic send_a(input logic [47:0] r, output int n);
    logic acc;
    rec_a   = r;
    valid_a = 1'b1;
    n       = 0;
    forever begin
      @(negedge clk);
      acc = ready_a;
      @(posedge clk);
      #1;
      n++;
      if (acc) break;
      if (n >= 100) begin
        checks++;
        errors++;
        $display("FAIL send_a timeout: not accepted after %0d cycles, expected accept", n);
        break;
      end
    end
  endtask

  task automatic send_b(input logic [31:0] r);
    logic acc;
    int n;
    rec_b   = r;
    valid_b = 1'b1;
    n       = 0;
    forever begin
      @(negedge clk);
      acc = ready_b;
      @(posedge clk);
      #1;
      n++;
      if (acc) break;
      if (n >= 100) begin
        checks++;
        errors++;
        $display("FAIL send_b timeout: not accepted after %0d cycles, expected accept", n);
        break;
      end
    end
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_a) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_a timeout: busy still 1 after 200 cycles, expected 0");
  endtask

  task automatic wait_idle_b();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_b) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_b timeout: busy still 1 after 200 cycles, expected 0");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    ack_a   = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int first, last, cnt, n_acc;
    bit low_seen, acc;
    logic [47:0] r1, r2, r3;

    r1 = 48'h0605_0403_0201;
    r2 = 48'h1615_1413_1211;
    r3 = 48'h2625_2423_2221;

    reset   = 1'b1;
    rec_a   = '0;
    valid_a = 1'b0;
    ack_a   = 1'b0;
    rec_b   = '0;
    valid_b = 1'b0;
    ack_b   = 1'b0;

    // Reset state
    #2;
    check("rst ready_a", ready_a, 1'b1);
    check("rst rdy_a", rdy_a, 1'b0);
    check("rst busy_a", busy_a, 1'b0);
    check("rst sent_a", sent_a, 16'd0);
    check("rst sample_a", sample_a, 8'h00);
    check("rst ready_b", ready_b, 1'b1);
    check("rst sent_b", sent_b, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post-rst ready_a", ready_a, 1'b1);

    // Spurious ack while idle
    ack_a = 1'b1;
    repeat (5) @(negedge clk);
    check("spur rdy_a", rdy_a, 1'b0);
    check("spur sent_a", sent_a, 16'd0);
    check("spur busy_a", busy_a, 1'b0);
    check("spur sample_a", sample_a, 8'h00);

    // Single record, continuous ack
    for (int k = 1; k <= 6; k++) qa.push_back(8'(k));
    @(posedge clk);
    #1;
    send_a(r1, n);
    valid_a = 1'b0;
    check("t1 accept cycles", n, 1);
    @(negedge clk);
    check("t1 latency rdy_a", rdy_a, 1'b1);
    check("t1 first sample", sample_a, 8'h01);
    wait_idle_a();
    check("t1 rdy_a", rdy_a, 1'b0);
    check("t1 sent_a", sent_a, 16'd1);
    check("t1 busy_a", busy_a, 1'b0);
    check("t1 queue empty", qa.size(), 0);
    repeat (3) @(negedge clk);
    check("t1 sample holds", sample_a, 8'h06);

    // Back-to-back records with valid held high
    do_reset();
    push_a(48'hAAAA_AAAA_AA01);
    push_a(48'hBBBB_BBBB_BB02);
    rec_a    = 48'hAAAA_AAAA_AA01;
    valid_a  = 1'b1;
    ack_a    = 1'b1;
    first    = -1;
    last     = -1;
    cnt      = 0;
    n_acc    = 0;
    low_seen = 1'b0;
    for (int c = 0; c < 60 && (n_acc < 2 || busy_a); c++) begin
      @(negedge clk);
      if (rdy_a) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
      if (!ready_a) low_seen = 1'b1;
      acc = valid_a && ready_a;
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        if (n_acc == 1) rec_a = 48'hBBBB_BBBB_BB02;
        else valid_a = 1'b0;
      end
    end
    check("t2 rdy cycles", cnt, 12);
    check("t2 rdy span", last - first + 1, 12);
    check("t2 ready dropped", low_seen, 1'b1);
    check("t2 sent_a", sent_a, 16'd2);
    check("t2 queue empty", qa.size(), 0);

    // Backpressure: stalled first record, second in hold, third blocked
    do_reset();
    push_a(r1);
    send_a(r1, n);
    push_a(r2);
    send_a(r2, n);
    valid_a = 1'b0;
    check("t3 hold accept cycles", n, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3 stall sample", sample_a, 8'h01);
    end
    check("t3 rdy_a", rdy_a, 1'b1);
    check("t3 ready_a full", ready_a, 1'b0);
    check("t3 busy_a", busy_a, 1'b1);
    @(posedge clk);
    #1;
    push_a(r3);
    ack_a = 1'b1;
    send_a(r3, n);
    valid_a = 1'b0;
    check("t3 third accept cycles", n, 7);
    wait_idle_a();
    check("t3 sent_a", sent_a, 16'd3);
    check("t3 queue empty", qa.size(), 0);

    // Reset mid-record after three bytes
    do_reset();
    push_a(r1);
    ack_a = 1'b1;
    send_a(r1, n);
    valid_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ack_a = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t5 bytes consumed", qa.size(), 3);
    qa.delete();
    check("t5 rst rdy_a", rdy_a, 1'b0);
    check("t5 rst sent_a", sent_a, 16'd0);
    check("t5 rst ready_a", ready_a, 1'b1);
    check("t5 rst sample_a", sample_a, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5 post ready_a", ready_a, 1'b1);
    check("t5 post rdy_a", rdy_a, 1'b0);
    @(posedge clk);
    #1;
    push_a(r2);
    ack_a = 1'b1;
    send_a(r2, n);
    valid_a = 1'b0;
    wait_idle_a();
    check("t5 sent_a", sent_a, 16'd1);
    check("t5 queue empty", qa.size(), 0);

    // MSB-first 4-byte instance and counter wrap
    @(posedge clk);
    #1;
    ack_b = 1'b1;
    qb.push_back(8'h11);
    qb.push_back(8'h22);
    qb.push_back(8'h33);
    qb.push_back(8'h44);
    send_b(32'h1122_3344);
    for (int i = 1; i < 15; i++) begin
      push_b({8'(i), 8'(i + 8'h40), 8'(i + 8'h80), 8'(i + 8'hC0)});
      send_b({8'(i), 8'(i + 8'h40), 8'(i + 8'h80), 8'(i + 8'hC0)});
    end
    valid_b = 1'b0;
    wait_idle_b();
    check("t6 sent_b 15", sent_b, 4'hF);
    @(posedge clk);
    #1;
    push_b(32'hDEAD_BEEF);
    send_b(32'hDEAD_BEEF);
    valid_b = 1'b0;
    wait_idle_b();
    check("t6 sent_b wrap", sent_b, 4'h0);
    check("t6 queue empty", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
